// File: rtl/exu_seq_ctrl.sv
// Multi-cycle instruction sequencer: owns the PC, runs fetch and load/store
// handshakes, and retires one instruction at a time with a watchdog per wait state.
module exu_seq_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] pc,
   output logic        ifu_req_valid,
   input  logic        ifu_req_ready,
   input  logic        ifu_resp_valid,
   output logic        ifu_resp_ready,
   input  logic [31:0] ifu_resp_inst,
   output logic [31:0] inst_id,
   input  logic [31:0] dnpc_ex,
   input  logic        reg_wen_ex,
   input  logic        mem_op_ex,
   input  logic        ebreak_ex,
   output logic        lsu_req_valid,
   input  logic        lsu_req_ready,
   input  logic        lsu_resp_valid,
   output logic        reg_wen_commit,
   output logic        commit,
   output logic [63:0] instret,
   output logic        halt,
   output logic        err
);

   localparam int unsigned    WDW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH_REQ,
      FETCH_WAIT,
      EXEC,
      MEM_REQ,
      MEM_WAIT,
      WB,
      HALT
   } state_t;

   state_t         state_q;
   logic [31:0]    dnpc_q;
   logic           reg_wen_q;
   logic           ebreak_q;
   logic [WDW-1:0] wd_q;
   logic           wd_expired;

   // The watchdog counts cycles already spent in the current REQ/WAIT state,
   // so the last permitted cycle is TIMEOUT-1; a handshake in that cycle still wins.
   always_comb begin
      wd_expired = (wd_q == WD_LAST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         pc             <= RESET_PC;
         inst_id        <= '0;
         instret        <= '0;
         dnpc_q         <= '0;
         reg_wen_q      <= 1'b0;
         ebreak_q       <= 1'b0;
         wd_q           <= '0;
         ifu_req_valid  <= 1'b0;
         ifu_resp_ready <= 1'b0;
         lsu_req_valid  <= 1'b0;
         reg_wen_commit <= 1'b0;
         commit         <= 1'b0;
         halt           <= 1'b0;
         err            <= 1'b0;
      end else begin
         commit         <= 1'b0;
         reg_wen_commit <= 1'b0;
         case (state_q)
            IDLE: begin
               state_q       <= FETCH_REQ;
               ifu_req_valid <= 1'b1;
               wd_q          <= '0;
            end
            FETCH_REQ: begin
               if (ifu_req_ready) begin
                  state_q        <= FETCH_WAIT;
                  ifu_req_valid  <= 1'b0;
                  ifu_resp_ready <= 1'b1;
                  wd_q           <= '0;
               end else if (wd_expired) begin
                  state_q       <= HALT;
                  ifu_req_valid <= 1'b0;
                  halt          <= 1'b1;
                  err           <= 1'b1;
               end else begin
                  wd_q <= wd_q + WDW'(1);
               end
            end
            FETCH_WAIT: begin
               if (ifu_resp_valid) begin
                  state_q        <= EXEC;
                  ifu_resp_ready <= 1'b0;
                  inst_id        <= ifu_resp_inst;
               end else if (wd_expired) begin
                  state_q        <= HALT;
                  ifu_resp_ready <= 1'b0;
                  halt           <= 1'b1;
                  err            <= 1'b1;
               end else begin
                  wd_q <= wd_q + WDW'(1);
               end
            end
            EXEC: begin
               dnpc_q    <= dnpc_ex;
               reg_wen_q <= reg_wen_ex;
               ebreak_q  <= ebreak_ex;
               if (dnpc_ex[1:0] != 2'b00) begin
                  state_q <= HALT;
                  halt    <= 1'b1;
                  err     <= 1'b1;
               end else if (mem_op_ex) begin
                  state_q       <= MEM_REQ;
                  lsu_req_valid <= 1'b1;
                  wd_q          <= '0;
               end else begin
                  state_q        <= WB;
                  commit         <= 1'b1;
                  reg_wen_commit <= reg_wen_ex;
               end
            end
            MEM_REQ: begin
               if (lsu_req_ready) begin
                  state_q       <= MEM_WAIT;
                  lsu_req_valid <= 1'b0;
                  wd_q          <= '0;
               end else if (wd_expired) begin
                  state_q       <= HALT;
                  lsu_req_valid <= 1'b0;
                  halt          <= 1'b1;
                  err           <= 1'b1;
               end else begin
                  wd_q <= wd_q + WDW'(1);
               end
            end
            MEM_WAIT: begin
               if (lsu_resp_valid) begin
                  state_q        <= WB;
                  commit         <= 1'b1;
                  reg_wen_commit <= reg_wen_q;
               end else if (wd_expired) begin
                  state_q <= HALT;
                  halt    <= 1'b1;
                  err     <= 1'b1;
               end else begin
                  wd_q <= wd_q + WDW'(1);
               end
            end
            WB: begin
               pc      <= dnpc_q;
               instret <= instret + 64'd1;
               if (ebreak_q) begin
                  state_q <= HALT;
                  halt    <= 1'b1;
               end else begin
                  state_q       <= FETCH_REQ;
                  ifu_req_valid <= 1'b1;
                  wd_q          <= '0;
               end
            end
            HALT: begin
               state_q <= HALT;
            end
         endcase
      end
   end

endmodule

// File: doc/exu_seq_ctrl.md
Name: exu_seq_ctrl

Overview:
Multi-cycle sequencer for the NPC core. It owns the architectural PC, drives the instruction-fetch and load/store handshakes, and holds the fetched instruction stable for decode/execute. It samples the execute stage's next-PC and write-enable, and releases a single-cycle register-file write strobe per instruction. It is the only block that advances the PC or commits an instruction.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset.
TIMEOUT, 255, maximum cycles spent in any REQ/WAIT state before an error halt; must be ≥1.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-high
pc  out  32  current instruction address; also drives ifu_addr
ifu_req_valid  out  1  fetch request valid
ifu_req_ready  in  1  fetch request accepted
ifu_resp_valid  in  1  fetch data valid
ifu_resp_ready  out  1  ready to accept fetch data
ifu_resp_inst  in  32  fetched instruction
inst_id  out  32  latched instruction for decode/execute
dnpc_ex  in  32  next PC from execute stage
reg_wen_ex  in  1  execute-stage register write request
mem_op_ex  in  1  current instruction is a load or store
ebreak_ex  in  1  current instruction is ebreak
lsu_req_valid  out  1  data-memory request valid
lsu_req_ready  in  1  data-memory request accepted
lsu_resp_valid  in  1  data-memory response or store acknowledge
reg_wen_commit  out  1  one-cycle register-file write strobe
commit  out  1  one-cycle pulse when an instruction retires
instret  out  64  count of retired instructions
halt  out  1  core stopped (sticky until reset)
err  out  1  halt caused by an error (sticky until reset)

Behaviour:
- Reset (async, immediate): state = IDLE; pc = RESET_PC; inst_id = 0; instret = 0; all valid, ready, strobe, halt and err outputs = 0.
- States: IDLE, FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT.
- IDLE: moves to FETCH_REQ after one cycle.
- FETCH_REQ: ifu_req_valid = 1. pc is stable while valid. On ifu_req_ready = 1, go to FETCH_WAIT.
- FETCH_WAIT: ifu_resp_ready = 1. On ifu_resp_valid = 1, latch ifu_resp_inst into inst_id and go to EXEC.
- A response arriving in FETCH_REQ is ignored. Memory must not respond in the same cycle it accepts the request.
- EXEC: one cycle. Latch dnpc_ex, reg_wen_ex and ebreak_ex into internal registers.
  - If dnpc_ex[1:0] ≠ 0: go to HALT with err = 1. No writeback, no commit.
  - Else if mem_op_ex = 1: go to MEM_REQ.
  - Else: go to WB.
- MEM_REQ: lsu_req_valid = 1 until lsu_req_ready, then go to MEM_WAIT.
- MEM_WAIT: on lsu_resp_valid, go to WB.
- WB: one cycle.
  - reg_wen_commit = latched reg_wen; commit = 1; pc ← latched dnpc; instret += 1.
  - Next state is HALT if latched ebreak is set (halt = 1, err = 0), else FETCH_REQ.
- HALT: absorbing; only reset exits it. All handshake outputs = 0 and pc is frozen.
- inst_id holds its value from the FETCH_WAIT capture until the next capture.
- Watchdog:
  - Counter clears on entry to each REQ/WAIT state and increments every cycle spent there.
  - When it reaches TIMEOUT, go to HALT with err = 1 and drop any pending valid.
- Latency: a zero-wait non-memory instruction takes 4 cycles (FETCH_REQ, FETCH_WAIT, EXEC, WB). A zero-wait memory instruction takes 6.
- instret wraps modulo 2^64. pc arithmetic is not performed here; dnpc_ex is used verbatim.
- Reset mid-transaction: all valids drop immediately. Outstanding memory responses after reset are the memory's responsibility.

Test Plan:
- Reset, then hold rst low with zero-wait memories -> pc = 0x8000_0000 on first FETCH_REQ; ifu_req_valid asserts in cycle 2 after reset release.
- Three non-branch instructions, dnpc = pc+4, reg_wen_ex = 1 -> commit and reg_wen_commit pulse every 4 cycles; pc goes 0x8000_0000 → 0x8000_0004 → 0x8000_0008; instret = 3.
- Jump with dnpc_ex = 0x8000_0100 -> after WB, next fetch address = 0x8000_0100.
- Load with lsu_req_ready low for 2 cycles and response 3 cycles later -> lsu_req_valid held steady; commit occurs exactly one cycle after lsu_resp_valid.
- ifu_req_ready held low for TIMEOUT = 4 cycles -> halt = 1, err = 1, ifu_req_valid = 0, no commit.
- ebreak_ex = 1 -> one commit pulse, then halt = 1, err = 0, pc frozen. Then dnpc_ex = 0x8000_0002 in a fresh run -> halt = 1, err = 1, no reg_wen_commit. Async rst in MEM_WAIT -> outputs cleared within the same cycle.
